// File: rtl/hilbert_mask_if.sv
// Bin stream into and out of the Hilbert mask stage; the master drives input bins, the slave returns masked bins.
interface hilbert_mask_if #(parameter int total_bits = 32);
    logic                         ED;
    logic                         START;
    logic signed [total_bits-1:0] DReal;
    logic signed [total_bits-1:0] DImag;
    logic signed [total_bits-1:0] DOReal;
    logic signed [total_bits-1:0] DOImag;
    logic                         VLD;
    logic                         RDY;
    logic                         DONE;

    modport master (output ED, START, DReal, DImag, input DOReal, DOImag, VLD, RDY, DONE);
    modport slave  (input ED, START, DReal, DImag, output DOReal, DOImag, VLD, RDY, DONE);
endinterface

// File: rtl/hilbert_mask.sv
// Streaming analytic-signal mask: keeps bins 0 and N/2, doubles 1..N/2-1, zeroes the rest, one-cycle latency.
// Define HILBERT_MASK_SAT_EN to saturate doubled bins instead of wrapping.
module hilbert_mask #(
    parameter int total_bits = 32,
    parameter int N          = 16,
    parameter int LOGN       = 4
) (
    input logic             CLK,
    input logic             RST,
    hilbert_mask_if.slave   bus
);
    localparam logic [0:0]      IDLE = 1'b0;
    localparam logic [0:0]      RUN  = 1'b1;
    localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [0:0]                   state;
    logic [LOGN-1:0]              k;
    logic                         accept;
    logic signed [total_bits-1:0] m_re, m_im;
    logic signed [total_bits-1:0] do_re, do_im;
    logic                         vld, rdy, done;

    function automatic logic signed [total_bits-1:0] dbl(input logic signed [total_bits-1:0] x);
`ifdef HILBERT_MASK_SAT_EN
        // The two top bits disagree exactly when 2*x leaves the signed range.
        if (x[total_bits-1] != x[total_bits-2])
            return x[total_bits-1] ? {1'b1, {(total_bits-1){1'b0}}} : {1'b0, {(total_bits-1){1'b1}}};
        return {x[total_bits-2:0], 1'b0};
`else
        return {x[total_bits-2:0], 1'b0};
`endif
    endfunction

    // START pre-empts the bin on the same cycle, even mid-frame.
    assign accept = (state == RUN) && bus.ED && !bus.START;

    always_comb begin
        m_re = '0;
        m_im = '0;
        if (k == '0 || k == HALF) begin
            m_re = bus.DReal;
            m_im = bus.DImag;
        end else if (k < HALF) begin
            m_re = dbl(bus.DReal);
            m_im = dbl(bus.DImag);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            k     <= '0;
            do_re <= '0;
            do_im <= '0;
            vld   <= 1'b0;
            rdy   <= 1'b0;
            done  <= 1'b0;
        end else begin
            vld  <= accept;
            rdy  <= accept && (k == '0);
            done <= accept && (k == LAST);
            if (accept) begin
                do_re <= m_re;
                do_im <= m_im;
            end
            if (bus.START) begin
                state <= RUN;
                k     <= '0;
            end else if (accept) begin
                if (k == LAST) begin
                    state <= IDLE;
                    k     <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

    assign bus.DOReal = do_re;
    assign bus.DOImag = do_im;
    assign bus.VLD    = vld;
    assign bus.RDY    = rdy;
    assign bus.DONE   = done;
endmodule

// File: tb/tb_hilbert_mask.sv
// Scoreboard bench for hilbert_mask: directed frames push expected bins, a negedge monitor pops and compares.
module tb_hilbert_mask;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilbert_mask_if bus ();
    hilbert_mask dut (.CLK(clk), .RST(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        rdy;
        logic        done;
    } exp_t;

    localparam logic [31:0] A  = 32'h0001_0000;
    localparam logic [31:0] B  = 32'hFFFF_0000;
    localparam logic [31:0] OA = 32'h4000_0000;
    localparam logic [31:0] OB = 32'hC000_0000;

    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_pass = 0;
    int vld_cnt = 0, rdy_cnt = 0, done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    // Hand-derived doubling: positive overflow iff input in [0x40000000,0x7FFFFFFF], negative iff below 0xC0000000.
    function automatic logic [31:0] dbl(input logic [31:0] x);
`ifdef HILBERT_MASK_SAT_EN
        if (!x[31] && x >= 32'h4000_0000) return 32'h7FFF_FFFF;
        if (x[31] && x < 32'hC000_0000) return 32'h8000_0000;
`endif
        return x * 2;
    endfunction

    function automatic exp_t expv(input int k, input logic [31:0] re, input logic [31:0] im);
        exp_t r;
        r.rdy  = (k == 0);
        r.done = (k == 15);
        if (k == 0 || k == 8) begin r.re = re; r.im = im; end
        else if (k < 8) begin r.re = dbl(re); r.im = dbl(im); end
        else begin r.re = 32'h0; r.im = 32'h0; end
        return r;
    endfunction

    task automatic step(input logic ed, input logic st, input logic [31:0] re, input logic [31:0] im);
        bus.ED = ed; bus.START = st; bus.DReal = re; bus.DImag = im;
        @(posedge clk); #1;
    endtask

    task automatic bin(input int k, input logic [31:0] re, input logic [31:0] im);
        q.push_back(expv(k, re, im));
        step(1'b1, 1'b0, re, im);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clr();
        vld_cnt = 0; rdy_cnt = 0; done_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (bus.VLD === 1'b1) begin
            vld_cnt++;
            if (bus.RDY)  rdy_cnt++;
            if (bus.DONE) done_cnt++;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_vld actual=1 expected=0 t=%0t", $time);
            end else begin
                e = q.pop_front();
                chk("out_re", bus.DOReal, e.re);
                chk("out_im", bus.DOImag, e.im);
                chk("out_rdy", {31'b0, bus.RDY}, {31'b0, e.rdy});
                chk("out_done", {31'b0, bus.DONE}, {31'b0, e.done});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.ED = 1'b0; bus.START = 1'b0; bus.DReal = '0; bus.DImag = '0;
        @(posedge clk); #1;
        step(1'b1, 1'b1, A, B);
        chk("rst_vld", {31'b0, bus.VLD}, 32'h0);
        chk("rst_rdy", {31'b0, bus.RDY}, 32'h0);
        chk("rst_done", {31'b0, bus.DONE}, 32'h0);
        chk("rst_re", bus.DOReal, 32'h0);
        chk("rst_im", bus.DOImag, 32'h0);
        rst = 1'b0;

        // IDLE ignores ED without START
        clr();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, A + i, B);
        idle(1);
        chk("idle_vld_cnt", vld_cnt, 0);
        chk("idle_re", bus.DOReal, 32'h0);
        chk("idle_im", bus.DOImag, 32'h0);

        // single frame
        clr();
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 16; k++) bin(k, A, B);
        idle(2);
        chk("f1_vld_cnt", vld_cnt, 16);
        chk("f1_rdy_cnt", rdy_cnt, 1);
        chk("f1_done_cnt", done_cnt, 1);

        // ED gaps 1,0,0 then back-to-back overflow frame
        clr();
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            bin(k, A, B);
            if (k < 15) begin
                step(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
                step(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
            end
            if (k == 14) chk("gap_no_early_done", done_cnt, 0);
        end
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k == 3 || k == 8) bin(k, OA, OB);
            else bin(k, A, B);
        end
        idle(2);
        chk("b2b_vld_cnt", vld_cnt, 32);
        chk("b2b_rdy_cnt", rdy_cnt, 2);
        chk("b2b_done_cnt", done_cnt, 2);

        // mid-frame restart with ED=1 on the START cycle
        clr();
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) bin(k, A, B);
        step(1'b1, 1'b1, A, B);
        chk("restart_vld", {31'b0, bus.VLD}, 32'h0);
        chk("hold_re", bus.DOReal, 32'h0002_0000);
        chk("hold_im", bus.DOImag, 32'hFFFE_0000);
        for (int k = 0; k < 16; k++) bin(k, A, B);
        idle(2);
        chk("restart_vld_cnt", vld_cnt, 21);
        chk("restart_rdy_cnt", rdy_cnt, 2);
        chk("restart_done_cnt", done_cnt, 1);

        // reset mid-frame, then ED ignored until START
        clr();
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) bin(k, A, B);
        rst = 1'b1;
        step(1'b1, 1'b0, A, B);
        rst = 1'b0;
        chk("midrst_vld", {31'b0, bus.VLD}, 32'h0);
        chk("midrst_re", bus.DOReal, 32'h0);
        chk("midrst_im", bus.DOImag, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, A, B);
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_vld_cnt", vld_cnt, 10);
        step(1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 16; k++) bin(k, A, B);

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(1);
        chk("queue_drained", q.size(), 0);
        chk("final_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
